// File: rtl/ldpc_codeword_pack_if.sv
// Byte-stream bundle of ldpc_codeword_pack: message input (s_*) and codeword output (m_*).
interface ldpc_codeword_pack_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_last;
   logic       m_ready;

   // Environment side: produces the message frame and consumes the codeword.
   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

   // Block side: consumes the message frame and produces the codeword.
   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/ldpc_codeword_pack.sv
// Wraps the QC-LDPC encoder: feeds it one message frame, captures the parity
// stream it returns (which cannot be stalled) and emits a systematic codeword
// (message bytes then parity bytes) to a downstream consumer that can stall.
module ldpc_codeword_pack #(
   parameter int MSG_BYTES = 128,
   parameter int PAR_BYTES = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   ldpc_codeword_pack_if.slave  bus,
   output logic                 enc_en_start,
   output logic                 enc_en_din,
   output logic [7:0]           enc_d_in,
   input  logic                 enc_done,
   output logic                 enc_read_parity,
   input  logic                 enc_en_out,
   input  logic [7:0]           enc_d_out,
   output logic                 busy,
   output logic                 err
);
   localparam int TOT_BYTES = MSG_BYTES + PAR_BYTES;
   localparam int WR_W      = $clog2(MSG_BYTES + 1);
   localparam int PAR_W     = $clog2(PAR_BYTES + 1);
   localparam int OUT_W     = $clog2(TOT_BYTES + 1);
   localparam int MA_W      = $clog2(MSG_BYTES);
   localparam int PA_W      = $clog2(PAR_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_ENC_WAIT = 3'd2,
      ST_PAR_CAP  = 3'd3,
      ST_DRAIN    = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [WR_W-1:0]    wr_idx_q, wr_idx_d;
   logic [PAR_W-1:0]   par_idx_q, par_idx_d;
   logic [OUT_W-1:0]   out_idx_q, out_idx_d;     // next codeword byte to fetch
   logic               enc_en_start_q, enc_en_start_d;
   logic               enc_en_din_q, enc_en_din_d;
   logic [7:0]         enc_d_in_q, enc_d_in_d;
   logic               enc_read_parity_q, enc_read_parity_d;
   logic               m_valid_q, m_valid_d;
   logic [7:0]         m_data_q, m_data_d;
   logic               m_last_q, m_last_d;
   logic               err_q, err_d;

   logic [7:0]         msg_buf [MSG_BYTES];
   logic [7:0]         par_buf [PAR_BYTES];

   logic               s_hs_s;
   logic               m_hs_s;
   logic               par_wr_s;
   logic               eng_on_s;
   logic               msg_rd_s;
   logic               avail_s;
   logic               fetch_s;
   logic [OUT_W-1:0]   par_off_s;
   logic [7:0]         rd_data_s;

   assign s_hs_s    = (state_q == ST_LOAD) && bus.s_valid;
   assign m_hs_s    = m_valid_q && bus.m_ready;
   assign par_wr_s  = (state_q == ST_PAR_CAP) && enc_en_out;
   assign eng_on_s  = (state_q == ST_ENC_WAIT) || (state_q == ST_PAR_CAP) || (state_q == ST_DRAIN);
   assign msg_rd_s  = out_idx_q < OUT_W'(MSG_BYTES);
   assign par_off_s = out_idx_q - OUT_W'(MSG_BYTES);
   assign rd_data_s = msg_rd_s ? msg_buf[MA_W'(out_idx_q)] : par_buf[PA_W'(par_off_s)];

   // A byte may be fetched once it is in a buffer: message bytes always are, parity only after capture.
   always_comb begin
      avail_s = 1'b0;
      if (msg_rd_s) begin
         avail_s = 1'b1;
      end else if (out_idx_q < OUT_W'(TOT_BYTES)) begin
         avail_s = par_off_s < OUT_W'(par_idx_q);
      end else begin
         avail_s = 1'b0;
      end
   end

   // Load the output register when it is empty or being consumed, so a stalled byte stays put.
   assign fetch_s = eng_on_s && avail_s && (!m_valid_q || bus.m_ready);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic for the frame sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.s_valid) state_d = ST_LOAD;
            else             state_d = ST_IDLE;
         end
         ST_LOAD: begin
            if (s_hs_s && (wr_idx_q == WR_W'(MSG_BYTES - 1))) state_d = ST_ENC_WAIT;
            else                                              state_d = ST_LOAD;
         end
         ST_ENC_WAIT: begin
            if (enc_done) state_d = ST_PAR_CAP;
            else          state_d = ST_ENC_WAIT;
         end
         ST_PAR_CAP: begin
            if (par_wr_s && (par_idx_q == PAR_W'(PAR_BYTES - 1))) state_d = ST_DRAIN;
            else                                                  state_d = ST_PAR_CAP;
         end
         ST_DRAIN: begin
            if (m_hs_s && m_last_q) state_d = ST_IDLE;
            else                    state_d = ST_DRAIN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the control outputs, counters and output register.
   always_comb begin
      enc_en_start_d    = (state_q == ST_IDLE) && bus.s_valid;
      enc_en_din_d      = s_hs_s;
      enc_d_in_d        = s_hs_s ? bus.s_data : enc_d_in_q;
      enc_read_parity_d = (state_q == ST_ENC_WAIT) && enc_done;
      err_d             = err_q || (enc_en_out && (state_q != ST_PAR_CAP));
      wr_idx_d          = wr_idx_q;
      par_idx_d         = par_idx_q;
      out_idx_d         = out_idx_q;
      m_valid_d         = m_valid_q;
      m_data_d          = m_data_q;
      m_last_d          = m_last_q;
      if (state_q == ST_IDLE) begin
         wr_idx_d  = '0;
         par_idx_d = '0;
         out_idx_d = '0;
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end else begin
         if (s_hs_s)   wr_idx_d  = wr_idx_q + WR_W'(1);
         else          wr_idx_d  = wr_idx_q;
         if (par_wr_s) par_idx_d = par_idx_q + PAR_W'(1);
         else          par_idx_d = par_idx_q;
         if (fetch_s) begin
            out_idx_d = out_idx_q + OUT_W'(1);
            m_valid_d = 1'b1;
            m_data_d  = rd_data_s;
            m_last_d  = out_idx_q == OUT_W'(TOT_BYTES - 1);
         end else if (m_hs_s) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end else begin
            m_valid_d = m_valid_q;
         end
      end
   end

   // Output and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx_q          <= '0;
         par_idx_q         <= '0;
         out_idx_q         <= '0;
         enc_en_start_q    <= 1'b0;
         enc_en_din_q      <= 1'b0;
         enc_d_in_q        <= 8'h00;
         enc_read_parity_q <= 1'b0;
         m_valid_q         <= 1'b0;
         m_data_q          <= 8'h00;
         m_last_q          <= 1'b0;
         err_q             <= 1'b0;
      end else begin
         wr_idx_q          <= wr_idx_d;
         par_idx_q         <= par_idx_d;
         out_idx_q         <= out_idx_d;
         enc_en_start_q    <= enc_en_start_d;
         enc_en_din_q      <= enc_en_din_d;
         enc_d_in_q        <= enc_d_in_d;
         enc_read_parity_q <= enc_read_parity_d;
         m_valid_q         <= m_valid_d;
         m_data_q          <= m_data_d;
         m_last_q          <= m_last_d;
         err_q             <= err_d;
      end
   end

   // Message and parity buffers; contents need no reset.
   always_ff @(posedge clk) begin
      if (s_hs_s) begin
         msg_buf[MA_W'(wr_idx_q)] <= bus.s_data;
      end
      if (par_wr_s) begin
         par_buf[PA_W'(par_idx_q)] <= enc_d_out;
      end
   end

   assign bus.s_ready     = (state_q == ST_LOAD);
   assign bus.m_valid     = m_valid_q;
   assign bus.m_data      = m_data_q;
   assign bus.m_last      = m_last_q;
   assign enc_en_start    = enc_en_start_q;
   assign enc_en_din      = enc_en_din_q;
   assign enc_d_in        = enc_d_in_q;
   assign enc_read_parity = enc_read_parity_q;
   assign busy            = (state_q != ST_IDLE);
   assign err             = err_q;
endmodule
